// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 8-bit ALU between two
// valid/ready requesters. A granted request is latched, sent to the ALU for
// exactly one EXEC cycle, and the registered result is returned on a shared
// response channel tagged with the owning requester id.
//
// Arbitration: PRIO_FIXED=0 selects round-robin on ties; PRIO_FIXED=1 lets req0
// win every tie. Opcodes outside 1..OP_MAX are answered with resp_err=1 and
// resp_data=0, and the ALU is never sampled for them.
//
// Optional feature: define ALU_OPCOUNT_EN to add op_count[15:0], a saturating
// count of error-free response handshakes.
module alu_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int OP_MAX     = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_inst,
  input  logic [7:0] req0_op1,
  input  logic [7:0] req0_op2,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_inst,
  input  logic [7:0] req1_op1,
  input  logic [7:0] req1_op2,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic [3:0] alu_inst,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  input  logic [7:0] alu_sol
`ifdef ALU_OPCOUNT_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam logic [3:0] OpMaxC = 4'(OP_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic [3:0]  inst_q;
  logic [7:0]  op1_q;
  logic [7:0]  op2_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic [7:0]  resp_data_q;
  logic        resp_err_q;

  logic        sel_valid;
  logic        sel_id;
  logic        accept;
  logic        inst_legal;
  logic        resp_hs;

  // Requester selection for the current cycle (meaningful only in IDLE).
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_valid = req0_valid | req1_valid;
    sel_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_id = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      sel_id = req1_valid;
    end
  end

  assign accept     = (state_q == IDLE) && sel_valid;
  assign inst_legal = (inst_q != 4'd0) && (inst_q <= OpMaxC);
  assign resp_hs    = resp_valid_q && resp_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> EXEC on a grant, EXEC lasts one cycle,
  // RESP waits for the consumer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: readys only in IDLE, ALU driven only in EXEC
  // and only with a legal opcode.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_inst   = 4'd0;
    alu_op1    = 8'h00;
    alu_op2    = 8'h00;
    unique case (state_q)
      IDLE: begin
        req0_ready = sel_valid && (sel_id == 1'b0);
        req1_ready = sel_valid && (sel_id == 1'b1);
      end
      EXEC: begin
        alu_inst = inst_legal ? inst_q : 4'd0;
        alu_op1  = op1_q;
        alu_op2  = op2_q;
      end
      default: ;
    endcase
  end

  // Request latch and arbitration history, captured on the handshake edge.
  // NOTE: the latched operands are reset too; they are a handful of flops, not
  // a memory, and a defined value keeps alu_op1/alu_op2 clean after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      inst_q       <= 4'd0;
      op1_q        <= 8'h00;
      op2_q        <= 8'h00;
    end else if (accept) begin
      last_grant_q <= sel_id;
      owner_q      <= sel_id;
      inst_q       <= sel_id ? req1_inst : req0_inst;
      op1_q        <= sel_id ? req1_op1  : req0_op1;
      op2_q        <= sel_id ? req1_op2  : req0_op2;
    end
  end

  // Response register: loaded at the end of EXEC, held until the consumer
  // takes it. Illegal opcodes never sample alu_sol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 8'h00;
      resp_err_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= owner_q;
      resp_data_q  <= inst_legal ? alu_sol : 8'h00;
      resp_err_q   <= ~inst_legal;
    end else if (state_q == RESP && resp_hs) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

`ifdef ALU_OPCOUNT_EN
  logic [15:0] op_count_q;

  // Saturating count of error-free responses actually consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= 16'h0000;
    end else if (resp_hs && !resp_err_q && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance checked through a scoreboard
// (expected results queued at each request handshake, compared at each
// response handshake) plus a fixed-priority instance checked for grant bias.
// The external ALU is modelled here; illegal opcodes make it output garbage.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Round-robin instance signals.
  logic       req0_valid = 0, req1_valid = 0, resp_ready = 1;
  logic [3:0] req0_inst = 0, req1_inst = 0;
  logic [7:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic       req0_ready, req1_ready, resp_valid, resp_id, resp_err;
  logic [7:0] resp_data, alu_op1, alu_op2, alu_sol;
  logic [3:0] alu_inst;

  // Fixed-priority instance signals.
  logic       f_req0_valid = 0, f_req1_valid = 0, f_resp_ready = 1;
  logic [3:0] f_req0_inst = 4'd2, f_req1_inst = 4'd3;
  logic [7:0] f_req0_op1 = 8'h05, f_req0_op2 = 8'h03;
  logic [7:0] f_req1_op1 = 8'hF0, f_req1_op2 = 8'h3C;
  logic       f_req0_ready, f_req1_ready, f_resp_valid, f_resp_id, f_resp_err;
  logic [7:0] f_resp_data, f_alu_op1, f_alu_op2, f_alu_sol;
  logic [3:0] f_alu_inst;

`ifdef ALU_OPCOUNT_EN
  logic [15:0] op_count, f_op_count;
`endif

  function automatic logic [7:0] alu_ref(input logic [3:0] inst,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (inst)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a << b;
      4'd7:    return a >> b;
      4'd8:    return ~a;
      4'd9:    return a * b;
      default: return 8'hA5;
    endcase
  endfunction

  assign alu_sol   = alu_ref(alu_inst, alu_op1, alu_op2);
  assign f_alu_sol = alu_ref(f_alu_inst, f_alu_op1, f_alu_op2);

  alu_arbiter #(.PRIO_FIXED(0), .OP_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_inst(req0_inst),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_inst(req1_inst),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_inst(alu_inst), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sol(alu_sol)
`ifdef ALU_OPCOUNT_EN
    , .op_count(op_count)
`endif
  );

  alu_arbiter #(.PRIO_FIXED(1), .OP_MAX(9)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_inst(f_req0_inst),
    .req0_op1(f_req0_op1), .req0_op2(f_req0_op2),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_inst(f_req1_inst),
    .req1_op1(f_req1_op1), .req1_op2(f_req1_op2),
    .resp_valid(f_resp_valid), .resp_ready(f_resp_ready), .resp_id(f_resp_id),
    .resp_data(f_resp_data), .resp_err(f_resp_err),
    .alu_inst(f_alu_inst), .alu_op1(f_alu_op1), .alu_op2(f_alu_op2),
    .alu_sol(f_alu_sol)
`ifdef ALU_OPCOUNT_EN
    , .op_count(f_op_count)
`endif
  );

  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   f_grants0 = 0;
  int   f_ready1_seen = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic id, input logic [3:0] inst,
                                    input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.id = id;
    if (inst >= 4'd1 && inst <= 4'd9) begin
      e.data = alu_ref(inst, a, b);
      e.err  = 1'b0;
    end else begin
      e.data = 8'h00;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard monitor, sampling on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        sb_q.push_back(make_exp(1'b0, req0_inst, req0_op1, req0_op2));
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back(make_exp(1'b1, req1_inst, req1_op1, req1_op2));
        grant_log.push_back(1);
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_resp", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_resp_id", resp_id, e.id);
          check("sb_resp_data", resp_data, e.data);
          check("sb_resp_err", resp_err, e.err);
        end
      end
    end
  end

  // Fixed-priority monitor: req0 grants counted, any req1 ready flagged.
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_req1_ready) f_ready1_seen++;
      if (f_req0_valid && f_req0_ready) f_grants0++;
      if (f_resp_valid && f_resp_ready) begin
        check("fx_resp_id", f_resp_id, 0);
        check("fx_resp_data", f_resp_data, 8'h02);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int max_cycles);
    int cnt = 0;
    while (grant_log.size() < n && cnt < max_cycles) begin
      step();
      cnt++;
    end
    if (grant_log.size() < n) check("timeout_grants", 0, 1);
  endtask

  task automatic wait_drain(input int max_cycles);
    int cnt = 0;
    while ((sb_q.size() != 0 || resp_valid) && cnt < max_cycles) begin
      step();
      cnt++;
    end
    if (sb_q.size() != 0 || resp_valid) check("timeout_drain", 0, 1);
  endtask

  function automatic int grant_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : 9;
  endfunction

  initial begin
`ifdef ALU_OPCOUNT_EN
    logic [15:0] cnt_before;
`endif
    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_data", resp_data, 8'h00);
    check("rst_resp_err", resp_err, 0);
    check("rst_alu_inst", alu_inst, 4'd0);
    check("rst_alu_op1", alu_op1, 8'h00);
    check("rst_alu_op2", alu_op2, 8'h00);
`ifdef ALU_OPCOUNT_EN
    check("rst_op_count", op_count, 16'd0);
`endif
    #9 rst_n = 1'b1;
    step();

    // Single request from req0: 0F + 01.
    req0_inst = 4'd1; req0_op1 = 8'h0F; req0_op2 = 8'h01; req0_valid = 1'b1;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    step();
    check("t1_exec_alu_inst", alu_inst, 4'd1);
    check("t1_exec_alu_op1", alu_op1, 8'h0F);
    check("t1_exec_alu_op2", alu_op2, 8'h01);
    check("t1_exec_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    step();
    check("t1_resp_valid", resp_valid, 1);
    check("t1_resp_id", resp_id, 0);
    check("t1_resp_data", resp_data, 8'h10);
    check("t1_resp_err", resp_err, 0);
    check("t1_resp_alu_inst", alu_inst, 4'd0);
    step();
    check("t1_back_idle", resp_valid, 0);
`ifdef ALU_OPCOUNT_EN
    check("t1_op_count", op_count, 16'd1);
`endif

    // Round-robin with both requesters held, starting from reset history.
    rst_pulse();
    grant_log.delete();
    req0_inst = 4'd2; req0_op1 = 8'h05; req0_op2 = 8'h03; req0_valid = 1'b1;
    req1_inst = 4'd3; req1_op1 = 8'hF0; req1_op2 = 8'h3C; req1_valid = 1'b1;
    wait_grants(3, 30);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_grant0", grant_at(0), 0);
    check("rr_grant1", grant_at(1), 1);
    check("rr_grant2", grant_at(2), 0);
    wait_drain(20);

    // Illegal opcodes 0 and 12: error response, ALU never driven.
`ifdef ALU_OPCOUNT_EN
    cnt_before = op_count;
`endif
    req0_inst = 4'd0; req0_op1 = 8'h12; req0_op2 = 8'h34; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    check("ill0_alu_inst", alu_inst, 4'd0);
    wait_drain(10);
    req1_inst = 4'd12; req1_op1 = 8'h55; req1_op2 = 8'hAA; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    check("ill12_alu_inst", alu_inst, 4'd0);
    wait_drain(10);
`ifdef ALU_OPCOUNT_EN
    check("ill_op_count", op_count, cnt_before);
`endif

    // Backpressure: response held for 5 cycles while both requesters wait.
`ifdef ALU_OPCOUNT_EN
    cnt_before = op_count;
`endif
    resp_ready = 1'b0;
    req0_inst = 4'd1; req0_op1 = 8'h07; req0_op2 = 8'h08; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_data", resp_data, 8'h0F);
      check("bp_resp_id", resp_id, 0);
      check("bp_req0_ready", req0_ready, 0);
      check("bp_req1_ready", req1_ready, 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    step();
    check("bp_released", resp_valid, 0);
    req1_valid = 1'b1;
    #1;
    check("bp_idle_req1_ready", req1_ready, 1);
    req1_valid = 1'b0;
`ifdef ALU_OPCOUNT_EN
    check("bp_op_count", op_count, cnt_before + 16'd1);
`endif
    step();

    // Reset during EXEC of req1: transaction dropped, history restored.
    req1_inst = 4'd1; req1_op1 = 8'hFF; req1_op2 = 8'h01; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    check("mr_exec_alu_inst", alu_inst, 4'd1);
    check("mr_exec_alu_op1", alu_op1, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    check("mr_resp_valid", resp_valid, 0);
    check("mr_alu_inst", alu_inst, 4'd0);
    check("mr_alu_op1", alu_op1, 8'h00);
    check("mr_alu_op2", alu_op2, 8'h00);
    check("mr_resp_data", resp_data, 8'h00);
    sb_q.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_no_resp", resp_valid, 0);
    end
    grant_log.delete();
    req0_inst = 4'd5; req0_op1 = 8'h3C; req0_op2 = 8'h0F; req0_valid = 1'b1;
    req1_inst = 4'd4; req1_op1 = 8'h81; req1_op2 = 8'h18; req1_valid = 1'b1;
    wait_grants(1, 10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("mr_tie_grant", grant_at(0), 0);
    wait_drain(10);

    // Fixed priority: req0 takes every grant while both are held.
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    repeat (12) step();
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    repeat (4) step();
    check("fx_req0_grants", f_grants0, 4);
    check("fx_req1_ready_seen", f_ready1_seen, 0);

    check("sb_empty_at_end", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between two requesters (req0, req1) using valid/ready handshakes.
- Grants one requester at a time (round-robin or fixed priority) and latches its opcode and operands.
- Drives the ALU for one execute cycle, registers the result, and returns it on a shared response channel tagged with the requester id.
- Sits between the instruction-issue logic and the ALU; the ALU instance stays outside this block.

Parameters:
- PRIO_FIXED, 0, 0 = round-robin arbitration; 1 = req0 always wins when both requesters are valid.
- OP_MAX, 9, highest legal opcode; legal opcodes are 1..OP_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted on this edge if valid&ready
- req0_inst  in  4  requester 0 opcode
- req0_op1  in  8  requester 0 operand_1
- req0_op2  in  8  requester 0 operand_2
- req1_valid, req1_ready, req1_inst, req1_op1, req1_op2: same as req0, for requester 1
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response when valid&ready
- resp_id  out  1  requester that owns the response (0/1)
- resp_data  out  8  registered ALU result
- resp_err  out  1  opcode was outside 1..OP_MAX
- alu_inst  out  4  to ALU inst
- alu_op1  out  8  to ALU operand_1
- alu_op2  out  8  to ALU operand_2
- alu_sol  in  8  from ALU sol

Behaviour:
- Reset values: state=IDLE; resp_valid, resp_id, resp_err = 0; resp_data = 8'h00; alu_inst = 4'd0; alu_op1, alu_op2 = 8'h00; last_grant = 1, so req0 wins the first tie.
- IDLE:
  - reqN_ready = 1 only for the requester selected this cycle; the other ready = 0.
  - Selection: if only one requester is valid, select it. If both are valid: with PRIO_FIXED=1 select req0; with PRIO_FIXED=0 select the requester that is not last_grant.
  - On a handshake edge: latch inst/op1/op2, set owner id, update last_grant, go to EXEC.
  - With no valid requester, stay in IDLE; alu_inst = 0.
- EXEC (exactly 1 cycle):
  - Drive alu_inst/alu_op1/alu_op2 from the latched values; both readys = 0.
  - If the latched opcode is legal, resp_data <= alu_sol and resp_err <= 0.
  - If the opcode is illegal (0 or >OP_MAX), alu_inst is forced to 0, resp_data <= 8'h00 and resp_err <= 1; the ALU's undriven output is never sampled.
  - Set resp_valid <= 1 and resp_id <= owner; go to RESP.
- RESP:
  - Hold resp_valid, resp_data, resp_id and resp_err stable until resp_valid&resp_ready.
  - On that edge, clear resp_valid and return to IDLE. No new acceptance is made in the same cycle.
  - Readys = 0; alu_inst = 0.
- Latency and throughput:
  - Request accept edge E0 → resp_valid high after edge E1, i.e. visible one cycle after acceptance.
  - Best-case throughput is one operation per 3 cycles.
- Width rules: all results are truncated to 8 bits as the ALU produces them (add/sub wrap, shift amounts ≥8 give 0). This block adds no arithmetic of its own.
- Requester inputs may change freely while ready=0; only values at the handshake edge are used.
- Asynchronous reset mid-operation: return to IDLE immediately and drop the in-flight transaction, with no response issued. last_grant returns to 1.

Optional Feature:
- Macro ALU_OPCOUNT_EN.
- When defined, adds output op_count[15:0]:
  - Reset to 0.
  - Increments on every response handshake (resp_valid&resp_ready) with resp_err=0.
  - Saturates at 16'hFFFF; illegal-opcode responses are not counted.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 only: inst=1, op1=8'h0F, op2=8'h01 → req0_ready on the first cycle; alu_inst=1 during EXEC; then resp_valid=1, resp_id=0, resp_data=8'h10, resp_err=0.
- Both requesters valid and held, PRIO_FIXED=0: req0 inst=2 op=5,3; req1 inst=3 op=8'hF0,8'h3C; resp_ready=1 → grants alternate req0, req1, req0; resp_data 8'h02 then 8'h30.
- Same stimulus with PRIO_FIXED=1 → every grant goes to req0; req1_ready stays 0.
- Illegal opcode inst=0, then inst=12 → resp_err=1, resp_data=8'h00, alu_inst stays 0 throughout; with ALU_OPCOUNT_EN, op_count does not increment.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → response stays stable, both readys stay 0; releasing resp_ready completes the response and returns to IDLE.
- rst_n pulsed low during EXEC of req1 (inst=1, 8'hFF+8'h01) → outputs return to reset values asynchronously, no response appears; the next tie is granted to req0.
